// File: rtl/out_display_seq.sv
// Sequential seven-segment output path: captures a value, runs a multi-cycle
// double-dabble conversion and drives NUM_HEX active-low displays.
module out_display_digit (
  input  logic [3:0] digit,
  input  logic       dash,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    if (dash)       seg = 7'h3F;
    else if (blank) seg = 7'h7F;
    else begin
      unique case (digit)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = 7'h7F;
      endcase
    end
  end
endmodule

module out_display_seq #(
  parameter int WIDTH         = 32,
  parameter int NUM_HEX       = 8,
  parameter int SIGNED        = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       value,
  input  logic                   enable,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [7*NUM_HEX-1:0]   hex_out
);
  localparam int ND = NUM_HEX - SIGNED;
  localparam int NB = (WIDTH * 30103) / 100000 + 1;
  localparam int NP = (NB > NUM_HEX) ? NB : NUM_HEX;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;
  state_t state, state_n;

  logic [CW-1:0]           cnt;
  logic [WIDTH-1:0]        mag;
  logic [NB-1:0][3:0]      bcd, bcd_adj;
  logic                    sign_cv, neg_in, ovf_cv;

  logic [NB-1:0][3:0]      res_dig, dig_n;
  logic                    res_sign, sign_n, ovf_n, have_res, vis_n;
  logic [NP-1:0][3:0]      dig_pad;
  logic [ND-1:0]           lz;
  logic [NUM_HEX-1:0][6:0] seg_all, hex_q;
  logic                    upd;
  int                      msd;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = CONVERT;
      CONVERT: if (cnt == CW'(1)) state_n = UPDATE;
      UPDATE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign upd    = (state == UPDATE);
  assign neg_in = (SIGNED != 0) && value[WIDTH-1];

  always_comb begin
    for (int i = 0; i < NB; i++)
      bcd_adj[i] = (bcd[i] >= 4'd5) ? bcd[i] + 4'd3 : bcd[i];
  end

  // digits that do not fit on the digit displays flag overflow
  always_comb begin
    ovf_cv = 1'b0;
    for (int i = 0; i < NB; i++)
      if (i >= ND && bcd[i] != 4'd0) ovf_cv = 1'b1;
  end

  // next-cycle display content: fresh result during UPDATE, else held
  assign dig_n  = upd ? bcd     : res_dig;
  assign sign_n = upd ? sign_cv : res_sign;
  assign ovf_n  = upd ? ovf_cv  : overflow;
  assign vis_n  = upd | have_res;

  always_comb begin
    dig_pad = '0;
    dig_pad[NB-1:0] = dig_n;
    msd = 0;
    for (int i = 0; i < NP; i++)
      if (dig_pad[i] != 4'd0) msd = i;
    for (int i = 0; i < ND; i++)
      lz[i] = (BLANK_LEADING != 0) && (i > msd);
  end

  for (genvar g = 0; g < NUM_HEX; g++) begin : g_disp
    if (SIGNED != 0 && g == NUM_HEX - 1) begin : g_sign
      out_display_digit u_dig (.digit(4'd0), .dash(sign_n), .blank(!sign_n), .seg(seg_all[g]));
    end else begin : g_num
      out_display_digit u_dig (.digit(dig_pad[g]), .dash(ovf_n), .blank(lz[g]), .seg(seg_all[g]));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      mag      <= '0;
      bcd      <= '0;
      sign_cv  <= 1'b0;
      res_dig  <= '0;
      res_sign <= 1'b0;
      overflow <= 1'b0;
      have_res <= 1'b0;
      done     <= 1'b0;
      hex_q    <= '1;
    end else begin
      done     <= upd;
      res_dig  <= dig_n;
      res_sign <= sign_n;
      overflow <= ovf_n;
      have_res <= vis_n;
      hex_q    <= (enable && vis_n) ? seg_all : '1;
      unique case (state)
        IDLE: if (start) begin
          sign_cv <= neg_in;
          mag     <= neg_in ? (~value + 1'b1) : value;
          bcd     <= '0;
          cnt     <= CW'(WIDTH);
        end
        CONVERT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          cnt        <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hex_out = hex_q;
endmodule

// File: tb/tb_out_display_seq.sv
// Scoreboard bench for out_display_seq with default parameters plus a
// BLANK_LEADING=0 instance for the zero-padding case.
module tb_out_display_seq;
  localparam logic [6:0] B = 7'h7F, D = 7'h3F;

  logic        clock = 0, reset, start, start_nb, enable;
  logic [31:0] value;
  logic        busy, done, overflow, nb_busy, nb_done, nb_overflow;
  logic [55:0] hex_out, nb_hex;

  typedef struct { logic [55:0] hex; logic ovf; } exp_t;
  exp_t q[$], q_nb[$];
  int tests = 0, fails = 0;

  always #5 clock = ~clock;

  out_display_seq dut (
    .clock(clock), .reset(reset), .start(start), .value(value), .enable(enable),
    .busy(busy), .done(done), .overflow(overflow), .hex_out(hex_out));

  out_display_seq #(.BLANK_LEADING(0)) dut_nb (
    .clock(clock), .reset(reset), .start(start_nb), .value(value), .enable(enable),
    .busy(nb_busy), .done(nb_done), .overflow(nb_overflow), .hex_out(nb_hex));

  function automatic logic [55:0] mk(input logic [6:0] h7, h6, h5, h4, h3, h2, h1, h0);
    return {h7, h6, h5, h4, h3, h2, h1, h0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // monitors: compare whenever a done pulse is presented
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("hex", hex_out, e.hex);
        chk("overflow", overflow, e.ovf);
      end
    end
  end

  always @(negedge clock) begin
    if (nb_done === 1'b1) begin
      if (q_nb.size() == 0) chk("nb_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q_nb.pop_front();
        chk("nb_hex", nb_hex, e.hex);
        chk("nb_overflow", nb_overflow, e.ovf);
      end
    end
  end

  task automatic issue(input logic [31:0] v, input logic [55:0] h, input logic o);
    exp_t e;
    e.hex = h; e.ovf = o;
    q.push_back(e);
    value = v; start = 1;
    @(posedge clock); #1 start = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (1) begin
      @(posedge clock); #1;
      n++;
      if (done) break;
      if (n >= 100) begin chk("done_timeout", 0, 1); break; end
    end
  endtask

  task automatic run(input logic [31:0] v, input logic [55:0] h, input logic o);
    int n;
    issue(v, h, o);
    wait_done(n);
    chk("latency", n, 33);
    @(posedge clock); #1;
  endtask

  initial begin
    int n;
    exp_t e;
    reset = 1; start = 0; start_nb = 0; enable = 1; value = 0;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_hex", hex_out, {56{1'b1}});

    run(32'd12345,    mk(B, B, B, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12), 0);
    run(32'hFFFFCFC7, mk(D, B, B, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12), 0);
    run(32'hFFFFFFFF, mk(D, B, B, B, B, B, B, 7'h79), 0);
    run(32'd9999999,  mk(B, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10), 0);
    run(32'd10000000, mk(B, D, D, D, D, D, D, D), 1);
    run(32'h80000000, mk(D, D, D, D, D, D, D, D), 1);

    // zero on both the blanking and the zero-padding instance
    e.hex = mk(B, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40); e.ovf = 0;
    q_nb.push_back(e);
    start_nb = 1;
    issue(32'd0, mk(B, B, B, B, B, B, B, 7'h40), 0);
    start_nb = 0;
    wait_done(n);
    chk("latency_zero", n, 33);
    @(posedge clock); #1;

    // second start while busy is ignored
    issue(32'd777, mk(B, B, B, B, B, 7'h78, 7'h78, 7'h78), 0);
    repeat (4) @(posedge clock);
    #1 value = 32'd5; start = 1;
    @(posedge clock); #1 start = 0;
    chk("busy_mid", busy, 1);
    wait_done(n);
    repeat (40) @(posedge clock);
    #1;
    chk("hold_hex", hex_out, mk(B, B, B, B, B, 7'h78, 7'h78, 7'h78));

    enable = 0;
    @(posedge clock); #1;
    chk("en_off_hex", hex_out, {56{1'b1}});
    enable = 1;
    @(posedge clock); #1;
    chk("en_on_hex", hex_out, mk(B, B, B, B, B, 7'h78, 7'h78, 7'h78));

    // reset mid-conversion aborts it
    value = 32'd999; start = 1;
    @(posedge clock); #1 start = 0;
    repeat (10) @(posedge clock);
    #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hex", hex_out, {56{1'b1}});
    repeat (40) @(posedge clock);
    #1;
    chk("abort_hex_later", hex_out, {56{1'b1}});

    run(32'd42, mk(B, B, B, B, B, B, 7'h19, 7'h24), 0);
    repeat (3) @(posedge clock);
    chk("queue_empty", q.size() + q_nb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
